// File: rtl/reorder_buffer_pkg.sv
// Shared types and widths for the reorder buffer and the dispatch stage that feeds it.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// dispat_info layout, LSB first: isCsr, isSu, isBranch, rd0_reName[RD_W-1:0], pc[63:0].
// rd0_reName is {arch index[4:0], rename slot[RB-1:0]}. Its numeric value is also the
// bit index into the write-back log.
package reorder_buffer_pkg;

  localparam int RB      = 2;              // rename slot bits per architectural register
  localparam int RP      = 1 << RB;        // rename copies per architectural register
  localparam int RD_W    = 5 + RB;         // width of rd0_reName
  localparam int WB_W    = 32 * RP;        // one write-back bit per physical register
  localparam int PC_W    = 64;
  localparam int INFO_DW = PC_W + RD_W + 3;

  localparam int OFS_CSR = 0;
  localparam int OFS_SU  = 1;
  localparam int OFS_BR  = 2;
  localparam int OFS_RD  = 3;
  localparam int OFS_PC  = OFS_RD + RD_W;

  // Field order matches dispat_info bit for bit, so a straight cast unpacks it.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [RD_W-1:0] rd0;
    logic            is_branch;
    logic            is_su;
    logic            is_csr;
  } rob_entry_t;

  // Architectural index of a renamed destination. x0 never waits on write-back.
  function automatic logic [4:0] arch_idx(input logic [RD_W-1:0] rd0);
    return rd0[RD_W-1:RB];
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping queue pointer with an extra wrap bit; increments on inc, zeroes on clr.
// Latency: new value visible one cycle after inc/clr.
// Backpressure: none; the caller qualifies inc.
// Ports: clk, rst_n (async active-low), inc, clr (has priority over inc), ptr[AW:0].
module rob_ptr #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [AW:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit queue: holds dispatched instructions and retires the head once written back/resolved.
// Latency: a pushed entry can retire no earlier than the cycle after the push; commit is combinational from the head.
// Backpressure: reOrder_fifo_full when no slot is free or a flush cycle is in progress; a push that is not accepted is dropped.
// Ports: CLK, RSTn (async active-low); dispat_info/reOrder_fifo_push in, reOrder_fifo_full/empty out;
//        wbLog_qout write-back log; bru_res_vld/bru_mispredict in, bru_res_ack out;
//        commit_vld/pc/rd0, su_commit, csr_commit, flush out.
// Optional: define ROB_PERF_CNT_EN to add perf_commit_cnt[63:0] and perf_flush_cnt[31:0].
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DP = 16,
  parameter int AW = 4
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [INFO_DW-1:0] dispat_info,
  input  logic               reOrder_fifo_push,
  output logic               reOrder_fifo_full,
  output logic               reOrder_fifo_empty,
  input  logic [WB_W-1:0]    wbLog_qout,
  input  logic               bru_res_vld,
  input  logic               bru_mispredict,
  output logic               bru_res_ack,
  output logic               commit_vld,
  output logic [PC_W-1:0]    commit_pc,
  output logic [RD_W-1:0]    commit_rd0,
  output logic               su_commit,
  output logic               csr_commit,
`ifdef ROB_PERF_CNT_EN
  output logic [63:0]        perf_commit_cnt,
  output logic [31:0]        perf_flush_cnt,
`endif
  output logic               flush
);

  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [DP-1:0] valid;
  rob_entry_t    mem [DP];
  rob_entry_t    head;
  logic          head_vld;
  logic          ptr_full;
  logic          rd_done;
  logic          mispredict;
  logic          push_acc;

  assign rd_idx = rd_ptr[AW-1:0];
  assign wr_idx = wr_ptr[AW-1:0];

  rob_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (CLK),
    .rst_n (RSTn),
    .inc   (commit_vld),
    .clr   (mispredict),
    .ptr   (rd_ptr)
  );

  rob_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (CLK),
    .rst_n (RSTn),
    .inc   (push_acc),
    .clr   (mispredict),
    .ptr   (wr_ptr)
  );

  assign ptr_full           = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign reOrder_fifo_full  = ptr_full | flush;
  assign reOrder_fifo_empty = (wr_ptr == rd_ptr);

  assign head     = mem[rd_idx];
  assign head_vld = valid[rd_idx];

  // Destination x0 has nothing to write back, so stores/CSRs/branches to x0 retire without the log.
  assign rd_done    = (arch_idx(head.rd0) == 5'd0) || wbLog_qout[head.rd0];
  assign commit_vld = head_vld & ~flush & rd_done & (~head.is_branch | bru_res_vld);
  assign mispredict = commit_vld & head.is_branch & bru_mispredict;

  // A full queue still takes a push when the head retires in the same cycle: the freed
  // slot is exactly the one the write pointer lands on. The mispredict edge discards it.
  assign push_acc = reOrder_fifo_push & ~flush & (~ptr_full | commit_vld) & ~mispredict;

  assign bru_res_ack = commit_vld & head.is_branch;
  assign commit_pc   = commit_vld ? head.pc  : '0;
  assign commit_rd0  = commit_vld ? head.rd0 : '0;
  assign su_commit   = commit_vld & head.is_su;
  assign csr_commit  = commit_vld & head.is_csr;

  // Payload carries no reset; the valid vector alone decides what may commit.
  always_ff @(posedge CLK) begin
    if (push_acc) begin
      mem[wr_idx] <= rob_entry_t'(dispat_info);
    end
  end

  // Retire clears before push sets, so a same-slot push at full leaves the slot valid.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid <= '0;
    end else if (mispredict) begin
      valid <= '0;
    end else begin
      if (commit_vld) valid[rd_idx] <= 1'b0;
      if (push_acc)   valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      flush <= 1'b0;
    end else begin
      flush <= mispredict;
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      perf_commit_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (commit_vld) perf_commit_cnt <= perf_commit_cnt + 64'd1;
      if (flush)      perf_flush_cnt  <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, write-back gating, fill/overflow, push at full,
// store/CSR commit, branch resolve and mispredict flush, asynchronous reset mid-operation.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic               CLK = 1'b0;
  logic               RSTn;
  logic [INFO_DW-1:0] dispat_info;
  logic               reOrder_fifo_push;
  logic               reOrder_fifo_full;
  logic               reOrder_fifo_empty;
  logic [WB_W-1:0]    wbLog_qout;
  logic               bru_res_vld;
  logic               bru_mispredict;
  logic               bru_res_ack;
  logic               commit_vld;
  logic [PC_W-1:0]    commit_pc;
  logic [RD_W-1:0]    commit_rd0;
  logic               su_commit;
  logic               csr_commit;
  logic               flush;
`ifdef ROB_PERF_CNT_EN
  logic [63:0]        perf_commit_cnt;
  logic [31:0]        perf_flush_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  reorder_buffer #(.DP(16), .AW(4)) dut (
    .CLK                (CLK),
    .RSTn               (RSTn),
    .dispat_info        (dispat_info),
    .reOrder_fifo_push  (reOrder_fifo_push),
    .reOrder_fifo_full  (reOrder_fifo_full),
    .reOrder_fifo_empty (reOrder_fifo_empty),
    .wbLog_qout         (wbLog_qout),
    .bru_res_vld        (bru_res_vld),
    .bru_mispredict     (bru_mispredict),
    .bru_res_ack        (bru_res_ack),
    .commit_vld         (commit_vld),
    .commit_pc          (commit_pc),
    .commit_rd0         (commit_rd0),
    .su_commit          (su_commit),
    .csr_commit         (csr_commit),
`ifdef ROB_PERF_CNT_EN
    .perf_commit_cnt    (perf_commit_cnt),
    .perf_flush_cnt     (perf_flush_cnt),
`endif
    .flush              (flush)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INFO_DW-1:0] mk(input logic [63:0] pc, input logic [4:0] arch,
                                            input logic [RB-1:0] rn, input logic br,
                                            input logic su, input logic csr);
    return {pc, arch, rn, br, su, csr};
  endfunction

  // Inputs change 1 time unit after the rising edge; checks run 1 unit after that.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RSTn              = 1'b0;
    dispat_info       = '0;
    reOrder_fifo_push = 1'b0;
    wbLog_qout        = '0;
    bru_res_vld       = 1'b0;
    bru_mispredict    = 1'b0;
    #3;
    chk("rst_empty", 64'(reOrder_fifo_empty), 64'd1);
    chk("rst_full",  64'(reOrder_fifo_full),  64'd0);
    chk("rst_commit",64'(commit_vld),         64'd0);
    chk("rst_ack",   64'(bru_res_ack),        64'd0);
    chk("rst_flush", 64'(flush),              64'd0);
    step();
    RSTn = 1'b1;
    step();

    // Single entry x5.r1 waits for its write-back bit (index 5*4+1 = 21).
    dispat_info       = mk(64'h100, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
    reOrder_fifo_push = 1'b1;
    step();
    reOrder_fifo_push = 1'b0;
    #1;
    chk("one_not_empty", 64'(reOrder_fifo_empty), 64'd0);
    chk("one_wait_wb",   64'(commit_vld),         64'd0);
    step();
    wbLog_qout[21] = 1'b1;
    #1;
    chk("one_commit",    64'(commit_vld), 64'd1);
    chk("one_rd0",       64'(commit_rd0), 64'd21);
    chk("one_pc",        commit_pc,       64'h100);
    step();
    wbLog_qout = '0;
    #1;
    chk("one_empty",     64'(reOrder_fifo_empty), 64'd1);
    chk("one_no_commit", 64'(commit_vld),         64'd0);

    // Store to x0 commits on its first cycle as head; CSR pushed while the store retires.
    dispat_info       = mk(64'h180, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    reOrder_fifo_push = 1'b1;
    step();
    dispat_info       = mk(64'h184, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("st_commit", 64'(commit_vld), 64'd1);
    chk("st_su",     64'(su_commit),  64'd1);
    chk("st_csr",    64'(csr_commit), 64'd0);
    chk("st_pc",     commit_pc,       64'h180);
    step();
    reOrder_fifo_push = 1'b0;
    #1;
    chk("csr_commit", 64'(csr_commit), 64'd1);
    chk("csr_su",     64'(su_commit),  64'd0);
    chk("csr_pc",     commit_pc,       64'h184);
    step();
    chk("csr_empty",  64'(reOrder_fifo_empty), 64'd1);

    // Fill 16 entries with nothing written back; entry i has rd0 = x(i+1).r0, pc = i.
    for (int i = 0; i < 16; i++) begin
      dispat_info       = mk(64'(i), 5'(i + 1), 2'd0, 1'b0, 1'b0, 1'b0);
      reOrder_fifo_push = 1'b1;
      step();
      if (i == 14) chk("fill_15_not_full", 64'(reOrder_fifo_full), 64'd0);
    end
    chk("fill_16_full", 64'(reOrder_fifo_full), 64'd1);
    dispat_info = mk(64'hdead, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    reOrder_fifo_push = 1'b0;
    #1;
    chk("ovf_full",      64'(reOrder_fifo_full), 64'd1);
    chk("ovf_no_commit", 64'(commit_vld),        64'd0);

    // Head x1.r0 (bit 4) written back while a push arrives at full.
    wbLog_qout[4]     = 1'b1;
    dispat_info       = mk(64'h77, 5'd20, 2'd0, 1'b0, 1'b0, 1'b0);
    reOrder_fifo_push = 1'b1;
    #1;
    chk("pf_commit", 64'(commit_vld), 64'd1);
    chk("pf_pc",     commit_pc,       64'd0);
    step();
    reOrder_fifo_push = 1'b0;
    wbLog_qout        = '0;
    #1;
    chk("pf_still_full", 64'(reOrder_fifo_full), 64'd1);
    chk("pf_head_wait",  64'(commit_vld),        64'd0);

    // Drain in order: pcs 1..15, then the entry pushed at full; the dropped 0xdead never appears.
    wbLog_qout = '1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("drain_vld", 64'(commit_vld), 64'd1);
      chk("drain_pc",  commit_pc,       (k < 15) ? 64'(k + 1) : 64'h77);
      step();
    end
    chk("drain_empty", 64'(reOrder_fifo_empty), 64'd1);
    wbLog_qout = '0;

    // Correctly predicted branch: retires on resolution, no flush.
    dispat_info       = mk(64'h1f0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    reOrder_fifo_push = 1'b1;
    step();
    reOrder_fifo_push = 1'b0;
    #1;
    chk("br_wait_bru", 64'(commit_vld), 64'd0);
    bru_res_vld = 1'b1;
    #1;
    chk("br_ack",    64'(bru_res_ack), 64'd1);
    chk("br_commit", 64'(commit_vld),  64'd1);
    step();
    bru_res_vld = 1'b0;
    #1;
    chk("br_no_flush", 64'(flush),              64'd0);
    chk("br_empty",    64'(reOrder_fifo_empty), 64'd1);

    // Mispredicted branch with 5 younger entries; a push in the same cycle is dropped.
    dispat_info       = mk(64'h200, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    reOrder_fifo_push = 1'b1;
    step();
    for (int i = 1; i <= 5; i++) begin
      dispat_info = mk(64'h200 + 64'(i), 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    dispat_info    = mk(64'h2ff, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    bru_res_vld    = 1'b1;
    bru_mispredict = 1'b1;
    #1;
    chk("mp_ack",    64'(bru_res_ack), 64'd1);
    chk("mp_commit", 64'(commit_vld),  64'd1);
    chk("mp_pc",     commit_pc,        64'h200);
    step();
    bru_res_vld    = 1'b0;
    bru_mispredict = 1'b0;
    #1;
    chk("mp_flush",        64'(flush),              64'd1);
    chk("mp_empty",        64'(reOrder_fifo_empty), 64'd1);
    chk("mp_full",         64'(reOrder_fifo_full),  64'd1);
    chk("mp_flush_commit", 64'(commit_vld),         64'd0);
    step();
    reOrder_fifo_push = 1'b0;
    #1;
    chk("mp_flush_end",  64'(flush),              64'd0);
    chk("mp_not_full",   64'(reOrder_fifo_full),  64'd0);
    chk("mp_push_dropd", 64'(reOrder_fifo_empty), 64'd1);
    dispat_info       = mk(64'h300, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    reOrder_fifo_push = 1'b1;
    step();
    reOrder_fifo_push = 1'b0;
    #1;
    chk("post_flush_commit", 64'(commit_vld), 64'd1);
    chk("post_flush_pc",     commit_pc,       64'h300);
    step();

    // Asynchronous reset with 8 pending entries.
    for (int i = 0; i < 8; i++) begin
      dispat_info       = mk(64'h400 + 64'(i), 5'd3, 2'd2, 1'b0, 1'b0, 1'b0);
      reOrder_fifo_push = 1'b1;
      step();
    end
    reOrder_fifo_push = 1'b0;
    wbLog_qout[14]    = 1'b1;
    #1;
    chk("ar_pre_commit", 64'(commit_vld),         64'd1);
    chk("ar_pre_empty",  64'(reOrder_fifo_empty), 64'd0);
    RSTn = 1'b0;
    #1;
    chk("ar_empty",  64'(reOrder_fifo_empty), 64'd1);
    chk("ar_commit", 64'(commit_vld),         64'd0);
    chk("ar_flush",  64'(flush),              64'd0);
    chk("ar_full",   64'(reOrder_fifo_full),  64'd0);
`ifdef ROB_PERF_CNT_EN
    chk("ar_perf_commit", perf_commit_cnt,     64'd0);
    chk("ar_perf_flush",  64'(perf_flush_cnt), 64'd0);
`endif
    step();
    RSTn = 1'b1;
    step();
    chk("ar_after_empty", 64'(reOrder_fifo_empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
